// File: rtl/axis_axi4_wr_dma.sv
// AXI-Stream to AXI4 write DMA: one INCR burst in flight at a time (AW, then W, then B).
// Define AXIS_AXI4_WR_DMA_4K_SPLIT_EN to keep every burst inside a 4 KB page.
module axis_axi4_wr_dma #(
    parameter int ID_W      = 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic [DATA_W/8-1:0]   s_tkeep,
    input  logic                  s_tlast,
    output logic [ID_W-1:0]       AWID,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ADDR_W-1:0]     AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWLOCK,
    output logic [3:0]            AWCACHE,
    output logic [2:0]            AWPROT,
    output logic [3:0]            AWQOS,
    output logic [3:0]            AWREGION,
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WLAST,
    input  logic [ID_W-1:0]       BID,
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic [1:0]            BRESP
);
    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int LIM_W = LEN_W + 9;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(BYTES - 1));

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_RESP = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Burst beats: the smaller of what is left and the per-burst cap.
    function automatic logic [8:0] f_burst_beats(input logic [LIM_W-1:0] cap,
                                                 input logic [LEN_W-1:0] rem);
        return (LIM_W'(rem) < cap) ? 9'(rem) : 9'(cap);
    endfunction

`ifdef AXIS_AXI4_WR_DMA_4K_SPLIT_EN
    // Beats that still fit before the next 4 KB page, clipped to MAX_BURST.
    function automatic logic [LIM_W-1:0] f_page_cap(input logic [11:0] off);
        return (LIM_W'((13'h1000 - {1'b0, off}) >> SIZE) < LIM_W'(MAX_BURST)) ?
               LIM_W'((13'h1000 - {1'b0, off}) >> SIZE) : LIM_W'(MAX_BURST);
    endfunction
`endif

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_rem;
    logic [8:0]          r_beats;
    logic [8:0]          r_cnt;
    logic                r_cmd_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_awvalid;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [7:0]          r_awlen;
    logic [2:0]          r_awsize;
    logic [1:0]          r_awburst;
    logic                r_in_data;
    logic                r_bready;

    logic                w_whs;
    logic [ADDR_W-1:0]   w_next_addr;
    logic [LEN_W-1:0]    w_next_rem;
    logic [LIM_W-1:0]    w_cap_cur;
    logic [LIM_W-1:0]    w_cap_next;
    logic [ADDR_W-1:0]   w_load_addr;
    logic [8:0]          w_load_beats;
    logic                w_unused;

    assign w_whs       = WVALID & WREADY;
    assign w_next_addr = r_addr + (ADDR_W'(r_beats) << SIZE);
    assign w_next_rem  = r_rem - LEN_W'(r_beats);
`ifdef AXIS_AXI4_WR_DMA_4K_SPLIT_EN
    assign w_cap_cur   = f_page_cap(r_addr[11:0]);
    assign w_cap_next  = f_page_cap(w_next_addr[11:0]);
`else
    assign w_cap_cur   = LIM_W'(MAX_BURST);
    assign w_cap_next  = LIM_W'(MAX_BURST);
`endif
    assign w_unused    = ^{BID, s_tlast};

    // Next AW source: a new command computes from the latched state, a follow-on
    // burst computes from the post-response address so RESP can go straight to ADDR.
    always_comb begin
        w_load_addr  = r_addr;
        w_load_beats = f_burst_beats(w_cap_cur, r_rem);
        if (r_state == S_RESP) begin
            w_load_addr  = w_next_addr;
            w_load_beats = f_burst_beats(w_cap_next, w_next_rem);
        end else begin
            w_load_addr  = r_addr;
            w_load_beats = f_burst_beats(w_cap_cur, r_rem);
        end
    end

    // Control FSM with all handshake/status outputs registered.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= S_IDLE;
            r_addr      <= {ADDR_W{1'b0}};
            r_rem       <= {LEN_W{1'b0}};
            r_beats     <= 9'd0;
            r_cnt       <= 9'd0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_awvalid   <= 1'b0;
            r_awaddr    <= {ADDR_W{1'b0}};
            r_awlen     <= 8'd0;
            r_awsize    <= 3'd0;
            r_awburst   <= 2'd0;
            r_in_data   <= 1'b0;
            r_bready    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_addr      <= cmd_addr & ADDR_MASK;
                        r_rem       <= cmd_len;
                        r_err       <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_CALC;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                // A zero-length command also passes through here, so done lands
                // two cycles after the handshake just like the first AWVALID.
                S_CALC: begin
                    if (r_rem == {LEN_W{1'b0}}) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_beats   <= w_load_beats;
                        r_awaddr  <= w_load_addr;
                        r_awlen   <= 8'(w_load_beats - 9'd1);
                        r_awsize  <= 3'(SIZE);
                        r_awburst <= 2'b01;
                        r_awvalid <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_cnt     <= r_beats - 9'd1;
                        r_in_data <= 1'b1;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_whs) begin
                        if (r_cnt == 9'd0) begin
                            r_in_data <= 1'b0;
                            r_bready  <= 1'b1;
                            r_state   <= S_RESP;
                        end else begin
                            r_cnt <= r_cnt - 9'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (BVALID) begin
                        r_bready <= 1'b0;
                        r_err    <= r_err | (BRESP != 2'b00);
                        r_addr   <= w_next_addr;
                        r_rem    <= w_next_rem;
                        if (w_next_rem == {LEN_W{1'b0}}) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_beats   <= w_load_beats;
                            r_awaddr  <= w_load_addr;
                            r_awlen   <= 8'(w_load_beats - 9'd1);
                            r_awvalid <= 1'b1;
                            r_state   <= S_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign AWID      = {ID_W{1'b0}};
    assign AWVALID   = r_awvalid;
    assign AWADDR    = r_awaddr;
    assign AWLEN     = r_awlen;
    assign AWSIZE    = r_awsize;
    assign AWBURST   = r_awburst;
    assign AWLOCK    = 1'b0;
    assign AWCACHE   = 4'd0;
    assign AWPROT    = 3'd0;
    assign AWQOS     = 4'd0;
    assign AWREGION  = 4'd0;
    assign WVALID    = s_tvalid & r_in_data;
    assign s_tready  = WREADY & r_in_data;
    assign WDATA     = s_tdata;
    assign WSTRB     = s_tkeep;
    assign WLAST     = r_in_data & (r_cnt == 9'd0);
    assign BREADY    = r_bready;

endmodule

// File: tb/tb_axis_axi4_wr_dma.sv
// Randomized bench for axis_axi4_wr_dma: a burst-list reference model plus a
// random AXI slave / stream source, all driven from one single-threaded loop.
module tb_axis_axi4_wr_dma;
    logic        ACLK = 1'b0;
    logic        ARESET, cmd_valid, cmd_ready, busy, done, err;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        s_tvalid, s_tready, s_tlast;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic [0:0]  AWID, BID;
    logic        AWVALID, AWREADY, AWLOCK, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE, AWPROT;
    logic [1:0]  AWBURST, BRESP;
    logic [3:0]  AWCACHE, AWQOS, AWREGION;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;

    axis_axi4_wr_dma dut (
        .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .busy(busy), .done(done), .err(err),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tlast(s_tlast), .AWID(AWID), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWQOS(AWQOS),
        .AWREGION(AWREGION), .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
        .WSTRB(WSTRB), .WLAST(WLAST), .BID(BID), .BVALID(BVALID), .BREADY(BREADY),
        .BRESP(BRESP)
    );

    always #5 ACLK = ~ACLK;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] src_d[$];
    logic [7:0]  src_k[$];
    logic [63:0] exp_d[$];
    logic [7:0]  exp_k[$];
    logic [39:0] exp_aw[$];
    int          src_idx, err_burst, b_idx, w_left, aw_total, done_cnt;
    int          p_aw, p_w, p_s, p_b;
    bit          b_pending, w_open, aw_stall;
    logic        err_at_done;
    logic [31:0] snap_addr;
    logic [7:0]  snap_len;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: split a command into bursts using plain arithmetic.
    task automatic build_model(input logic [31:0] addr, input int len);
        logic [31:0] a = addr;
        int rem = len;
        int b;
        exp_aw.delete();
        while (rem > 0) begin
            b = (rem < 16) ? rem : 16;
`ifdef AXIS_AXI4_WR_DMA_4K_SPLIT_EN
            if ((4096 - int'(a[11:0])) / 8 < b) b = (4096 - int'(a[11:0])) / 8;
`endif
            exp_aw.push_back({a, 8'(b - 1)});
            a   = a + 32'(b * 8);
            rem = rem - b;
        end
    endtask

    // One clock: drive slave/source just after posedge, observe at negedge.
    task automatic cyc();
        logic [39:0] e;
        @(posedge ACLK);
        #1;
        if (src_idx < src_d.size()) begin
            s_tvalid = ($urandom_range(0, 99) < p_s);
            s_tdata  = src_d[src_idx];
            s_tkeep  = src_k[src_idx];
        end else begin
            s_tvalid = 1'($urandom_range(0, 1));
            s_tdata  = {$urandom, $urandom};
            s_tkeep  = 8'hFF;
        end
        AWREADY = ($urandom_range(0, 99) < p_aw);
        WREADY  = ($urandom_range(0, 99) < p_w);
        if (b_pending) begin
            if (!BVALID) begin
                BVALID = ($urandom_range(0, 99) < p_b);
                BRESP  = (b_idx == err_burst) ? 2'b10 : 2'b00;
            end
        end else begin
            BVALID = 1'b0;
            BRESP  = 2'b00;
        end
        @(negedge ACLK);
        if (AWVALID) begin
            check("aw_serialised", 64'({w_open, b_pending}), 64'd0);
            if (aw_stall) begin
                check("aw_stable_addr", 64'(AWADDR), 64'(snap_addr));
                check("aw_stable_len", 64'(AWLEN), 64'(snap_len));
            end
        end
        aw_stall  = AWVALID && !AWREADY;
        snap_addr = AWADDR;
        snap_len  = AWLEN;
        if (AWVALID && AWREADY) begin
            aw_total++;
            check("aw_fixed", 64'({AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWID}),
                  64'({3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0}));
            if (exp_aw.size() == 0) begin
                check("aw_extra", 64'd1, 64'd0);
            end else begin
                e = exp_aw.pop_front();
                check("aw_addr", 64'(AWADDR), 64'(e[39:8]));
                check("aw_len", 64'(AWLEN), 64'(e[7:0]));
                w_left = int'(e[7:0]) + 1;
            end
            w_open = 1'b1;
        end
        if (WVALID)   check("wvalid_in_data", 64'(w_open), 64'd1);
        if (s_tready) check("tready_in_data", 64'(w_open), 64'd1);
        if (WVALID && WREADY) begin
            src_idx++;
            w_left--;
            if (exp_d.size() == 0) begin
                check("w_extra", 64'd1, 64'd0);
            end else begin
                check("w_data", WDATA, exp_d.pop_front());
                check("w_strb", 64'(WSTRB), 64'(exp_k.pop_front()));
            end
            check("w_last", 64'(WLAST), 64'(w_left == 0));
            if (w_left <= 0) begin
                w_open    = 1'b0;
                b_pending = 1'b1;
            end
        end
        if (BREADY) check("bready_in_resp", 64'(b_pending), 64'd1);
        if (BVALID && BREADY) begin
            b_pending = 1'b0;
            b_idx++;
        end
        if (done) begin
            done_cnt++;
            err_at_done = err;
        end
    endtask

    task automatic setup_cmd(input logic [31:0] addr, input int len, input int perr);
        logic [63:0] d;
        logic [7:0]  k;
        src_d.delete(); src_k.delete(); exp_d.delete(); exp_k.delete();
        for (int i = 0; i < len; i++) begin
            d = {$urandom, $urandom};
            k = 8'($urandom_range(0, 255));
            src_d.push_back(d); src_k.push_back(k);
            exp_d.push_back(d); exp_k.push_back(k);
        end
        src_idx = 0; b_idx = 0; err_burst = perr; done_cnt = 0;
        build_model(addr, len);
    endtask

    task automatic issue_cmd(input logic [31:0] addr, input int len);
        bit hs = 1'b0;
        cmd_addr  = addr;
        cmd_len   = 16'(len);
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = cmd_ready;
            cyc();
        end
        if (!hs) check("cmd_handshake_timeout", 64'd0, 64'd1);
        cmd_valid = 1'b0;
        check("err_cleared", 64'(err), 64'd0);
        check("busy_after_cmd", 64'(busy), 64'd1);
        if (len != 0) begin
            check("awvalid_calc", 64'(AWVALID), 64'd0);
            cyc();
            check("awvalid_2cyc", 64'(AWVALID), 64'd1);
        end
    endtask

    task automatic run_cmd(input logic [31:0] addr, input int len, input int perr,
                           input int pa, input int pw, input int ps, input int pb);
        int nb, aw0;
        bit exp_err;
        p_aw = pa; p_w = pw; p_s = ps; p_b = pb;
        setup_cmd(addr, len, perr);
        nb      = exp_aw.size();
        exp_err = (perr >= 0) && (perr < nb);
        aw0     = aw_total;
        issue_cmd(addr, len);
        for (int i = 0; i < 4000 && done_cnt == 0; i++) cyc();
        if (done_cnt == 0) check("done_timeout", 64'd0, 64'd1);
        check("err_at_done", 64'(err_at_done), 64'(exp_err));
        for (int i = 0; i < 3; i++) cyc();
        check("done_once", 64'(done_cnt), 64'd1);
        check("aw_count", 64'(aw_total - aw0), 64'(nb));
        check("aw_left", 64'(exp_aw.size()), 64'd0);
        check("beats_left", 64'(exp_d.size()), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        check("err_sticky", 64'(err), 64'(exp_err));
    endtask

    initial begin
        int len, aw0;
        logic [31:0] addr;
        ARESET = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_len = 16'd0;
        s_tvalid = 1'b0; s_tdata = 64'd0; s_tkeep = 8'd0; s_tlast = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00; BID = 1'b0;
        p_aw = 100; p_w = 100; p_s = 100; p_b = 100;
        src_idx = 0; err_burst = -1; b_idx = 0; w_left = 0; aw_total = 0; done_cnt = 0;
        b_pending = 1'b0; w_open = 1'b0; aw_stall = 1'b0; err_at_done = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        check("rst_outputs", 64'({AWVALID, WVALID, BREADY, cmd_ready, busy, done, err, s_tready}), 64'd0);
        check("rst_aw_addr", 64'(AWADDR), 64'd0);
        check("rst_aw_fields", 64'({AWLEN, AWSIZE, AWBURST}), 64'd0);
        ARESET = 1'b0;
        cyc();
        check("rst_cmd_ready_rise", 64'(cmd_ready), 64'd1);

        run_cmd(32'h0000_1000, 3, -1, 100, 100, 100, 100);
        run_cmd(32'h0000_0000, 40, -1, 100, 100, 100, 100);
        run_cmd(32'h0000_0FE0, 8, -1, 100, 100, 100, 100);
        run_cmd(32'h0004_0200, 20, -1, 50, 40, 50, 40);
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(1, 60);
`ifdef AXIS_AXI4_WR_DMA_4K_SPLIT_EN
            addr = {12'($urandom), 8'($urandom), 12'($urandom_range(0, 511) * 8)};
`else
            addr = {12'($urandom), 8'($urandom), 12'($urandom_range(0, (4096 - len * 8) / 8) * 8)};
`endif
            run_cmd(addr, len, -1, $urandom_range(30, 100), $urandom_range(30, 100),
                    $urandom_range(30, 100), $urandom_range(30, 100));
        end

        run_cmd(32'h0000_5000, 40, 1, 70, 70, 70, 70);
        check("err_held_in_idle", 64'(err), 64'd1);

        // Zero-length command: done two cycles after the handshake, no AW at all.
        setup_cmd(32'h0000_7000, 0, -1);
        aw0 = aw_total;
        cmd_addr = 32'h0000_7000; cmd_len = 16'd0; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) cyc();
        cyc();
        cmd_valid = 1'b0;
        check("len0_done_early", 64'(done), 64'd0);
        check("len0_err_cleared", 64'(err), 64'd0);
        cyc();
        check("len0_done_2cyc", 64'(done), 64'd1);
        cyc();
        check("len0_done_pulse", 64'(done), 64'd0);
        check("len0_idle", 64'(busy), 64'd0);
        check("len0_no_aw", 64'(aw_total - aw0), 64'd0);

        run_cmd(32'h0000_6000, 5, -1, 100, 100, 100, 100);

        // Reset while W beats are moving.
        p_aw = 100; p_w = 100; p_s = 100; p_b = 100;
        setup_cmd(32'h0000_8000, 40, -1);
        issue_cmd(32'h0000_8000, 40);
        for (int i = 0; i < 200 && !WVALID; i++) cyc();
        check("rst_mid_in_data", 64'(WVALID), 64'd1);
        ARESET = 1'b1;
        cyc();
        check("rst_mid_quiet", 64'({AWVALID, WVALID, BREADY, busy, s_tready, done}), 64'd0);
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd0);
        src_d.delete(); src_k.delete(); exp_d.delete(); exp_k.delete(); exp_aw.delete();
        b_pending = 1'b0; w_open = 1'b0; aw_stall = 1'b0; src_idx = 0;
        ARESET = 1'b0;
        cyc();
        check("rst_mid_ready_back", 64'(cmd_ready), 64'd1);
        check("rst_mid_busy", 64'(busy), 64'd0);

        run_cmd(32'h0000_9000, 17, -1, 60, 60, 60, 60);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
